dmem_ctrl: RTL and testbench
============================

# dmem_ctrl

Parametrised data-memory block for the single-cycle MIPS datapath, superseding the flat word RAM. Provides a synchronous, byte-addressed 32-bit memory with a one-cycle req/ack handshake, registered read data, misalignment detection, and a hardware clear sweep that zeroes the array one word per cycle after reset instead of clearing all words in one event. Sits between the ALU address output / rt store data and the write-back mux.

## Interface
- DEPTH, 1024, number of 32-bit words; power of two, ≥ 4
- AW, $clog2(DEPTH)+2, byte-address width (derived; not overridden)
- clk  input  1  clock, rising edge
- clr  input  1  reset, asynchronous, active-high
- req  input  1  access request, sampled on rising clk
- we  input  1  1 = store, 0 = load (qualified by req)
- size  input  2  00 byte, 01 half, 10 word, 11 reserved
- sgn  input  1  1 = sign-extend sub-word loads, 0 = zero-extend
- addr  input  AW  byte address; word index = addr[AW-1:2]
- wdata  input  32  store data, right-aligned for sub-word stores
- rdata  output  32  load data, valid while ack = 1
- ack  output  1  one-cycle completion pulse for every accepted request
- err  output  1  valid with ack; 1 = misaligned or reserved size
- busy  output  1  1 = clear sweep running, requests ignored

## Operation
- FSM states: CLEAR, READY.
- clr = 1 (async): state ← CLEAR, sweep pointer ← 0, rdata ← 0, ack ← 0, err ← 0, busy ← 1. Any in-flight ack is dropped.
- CLEAR: each rising edge with clr = 0 writes 0 to mem[ptr], ptr ← ptr+1; the edge writing word DEPTH-1 moves to READY and drops busy. req ignored (not queued; requester retries).
- READY: request accepted on every edge with req = 1; back-to-back accepts allowed, one per cycle.
- Alignment: word needs addr[1:0] = 00; half needs addr[0] = 0; byte always aligned. size = 11 is an error.
- Error access: no array write; ack = 1, err = 1, rdata = 0.
- Little-endian lanes: byte lane k = addr[1:0] occupies bits 8k+7:8k; half lane uses addr[1] (bits 15:0 or 31:16).
- Store: byte writes wdata[7:0] into lane k only; half writes wdata[15:0] into its half only; word writes all 32 bits. Untouched lanes keep their value. rdata = 0 on store ack.
- Load: selected lane shifted to bit 0; upper bits = sign bit of lane if sgn = 1, else 0. sgn ignored for word loads.
- ack = 0 cycles: rdata and err hold 0.

## Timing
- Reset outputs: rdata 0, ack 0, err 0, busy 1.
- Clear sweep: exactly DEPTH rising edges after clr deasserts; busy falls after edge DEPTH; first request accepted on edge DEPTH+1.
- Latency: request accepted on edge N → ack, rdata, err registered at edge N, visible cycle N+1 (1 cycle).
- Store commits to array at edge N; load of same address accepted at edge N+1 returns the new value (no read-during-write hazard across cycles).
- Store and load never collide in one cycle (single port, one request per cycle).
- clr asserted mid-sweep or mid-access: sweep restarts from word 0; partially completed store of that edge is not guaranteed.

## Configuration
- DMEM_SUBWORD_EN defined: byte/half support as above (size, sgn, lane masking, sign extension).
- Not defined: size and sgn ignored, every access treated as word; err = 1 iff addr[1:0] ≠ 00; no byte-lane write logic synthesised.

## Test plan
- Reset clear: fill words 0..3 with 0xFFFFFFFF, pulse clr, wait → busy high exactly 1024 cycles; then load word at 0x00C → ack next cycle, rdata 0x00000000, err 0.
- Word store/load back-to-back: store 0xDEADBEEF @0x010, load @0x010 next cycle → second ack rdata 0xDEADBEEF, err 0; acks on consecutive cycles.
- Sub-word (DMEM_SUBWORD_EN): word 0x11223344 @0x020, sb 0xAA @0x021 → word reads 0x1122AA44; lb sgn=1 @0x021 → 0xFFFFFFAA; lhu @0x022 → 0x00001122.
- Misalign: word load @0x006, half store @0x003 → ack with err 1, rdata 0; following word load @0x000 shows word unchanged.
- Busy/ignore: assert req during sweep cycle 5 → no ack; clr re-asserted at sweep cycle 500 → busy stays high 1024 further cycles after deassert.
- Macro off: size=00 load @0x021 → err 1; size=00 store @0x020 of 0x000000AA writes full word 0x000000AA.

Source files
------------

// File: rtl/dmem_if.sv
// Data-memory request/response bundle: the requester drives the master side,
// and dmem_ctrl sits on the slave side.
interface dmem_if #(parameter int AW = 12);
  logic          req;
  logic          we;
  logic [1:0]    size;
  logic          sgn;
  logic [AW-1:0] addr;
  logic [31:0]   wdata;
  logic [31:0]   rdata;
  logic          ack;
  logic          err;
  logic          busy;

  modport master (output req, we, size, sgn, addr, wdata,
                  input  rdata, ack, err, busy);
  modport slave  (input  req, we, size, sgn, addr, wdata,
                  output rdata, ack, err, busy);
endinterface

// File: rtl/dmem_ctrl.sv
// Byte-addressed 32-bit data memory with a one-cycle ack and a post-reset zeroing sweep.
// Byte/half access is compiled in only when DMEM_SUBWORD_EN is defined; otherwise every access is a word access.
module dmem_ctrl #(
  parameter int DEPTH = 1024
) (
  input logic   clk,
  input logic   clr,
  dmem_if.slave bus
);
  localparam int AW = $clog2(DEPTH) + 2;
  localparam logic [AW-3:0] LAST = (AW-2)'(DEPTH - 1);

  typedef enum logic {CLEAR, READY} state_t;

  state_t      state;
  logic [AW-3:0] ptr;
  logic [31:0] mem [DEPTH];

  logic [AW-3:0] idx;
  logic [1:0]  lane;
  logic [31:0] word;
  logic        accept;
  logic        bad;
  logic [31:0] load_val;

  assign idx    = bus.addr[AW-1:2];
  assign lane   = bus.addr[1:0];
  assign word   = mem[idx];
  assign accept = (state == READY) && bus.req;

`ifdef DMEM_SUBWORD_EN
  logic [3:0]  be;
  logic [31:0] wlane;
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    bad      = 1'b0;
    be       = 4'hF;
    wlane    = bus.wdata;
    byte_v   = word[{lane, 3'b000} +: 8];
    half_v   = word[{lane[1], 4'b0000} +: 16];
    load_val = word;
    case (bus.size)
      2'b00: begin
        be       = 4'b0001 << lane;
        wlane    = {4{bus.wdata[7:0]}};
        load_val = {{24{bus.sgn & byte_v[7]}}, byte_v};
      end
      2'b01: begin
        bad      = lane[0];
        be       = lane[1] ? 4'b1100 : 4'b0011;
        wlane    = {2{bus.wdata[15:0]}};
        load_val = {{16{bus.sgn & half_v[15]}}, half_v};
      end
      2'b10:   bad = (lane != 2'b00);
      default: bad = 1'b1;
    endcase
  end
`else
  logic unused_sub;
  assign unused_sub = ^{bus.size, bus.sgn};
  assign bad        = (lane != 2'b00);
  assign load_val   = word;
`endif

  // The array has no reset so it maps onto block RAM; zeroing is done by the sweep.
  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      mem[ptr] <= '0;
    end else if (accept && bus.we && !bad) begin
`ifdef DMEM_SUBWORD_EN
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wlane[8*i +: 8];
      end
`else
      mem[idx] <= bus.wdata;
`endif
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state     <= CLEAR;
      ptr       <= '0;
      bus.rdata <= '0;
      bus.ack   <= 1'b0;
      bus.err   <= 1'b0;
      bus.busy  <= 1'b1;
    end else begin
      case (state)
        CLEAR: begin
          ptr       <= ptr + 1'b1;
          bus.rdata <= '0;
          bus.ack   <= 1'b0;
          bus.err   <= 1'b0;
          if (ptr == LAST) begin
            state    <= READY;
            bus.busy <= 1'b0;
          end
        end
        default: begin
          bus.ack   <= bus.req;
          bus.err   <= bus.req && bad;
          bus.rdata <= (bus.req && !bus.we && !bad) ? load_val : '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: vector table through a response scoreboard, plus hand-written reset and sweep sequences.
module tb_dmem_ctrl;
  localparam int DEPTH = 1024;
  localparam int AW    = 12;

  logic clk = 1'b0;
  logic clr = 1'b1;
  always #5 clk = ~clk;

  dmem_if #(.AW(AW)) bus ();

  dmem_ctrl #(.DEPTH(DEPTH)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  typedef struct {
    logic          we;
    logic [1:0]    size;
    logic          sgn;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
    logic [31:0]   exp_rdata;
    logic          exp_err;
  } vec_t;

  typedef struct {
    string       name;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  vec_t vecs[$];
  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic void add(input logic we, input logic [1:0] size, input logic sgn,
                              input logic [AW-1:0] addr, input logic [31:0] wdata,
                              input logic [31:0] exp_rdata, input logic exp_err);
    vec_t v;
    v.we = we; v.size = size; v.sgn = sgn; v.addr = addr; v.wdata = wdata;
    v.exp_rdata = exp_rdata; v.exp_err = exp_err;
    vecs.push_back(v);
  endfunction

  // Drives one request on the next negedge and records the response it must produce.
  task automatic issue(input string name, input vec_t v);
    exp_t e;
    @(negedge clk);
    bus.req   = 1'b1;
    bus.we    = v.we;
    bus.size  = v.size;
    bus.sgn   = v.sgn;
    bus.addr  = v.addr;
    bus.wdata = v.wdata;
    e.name = name; e.rdata = v.exp_rdata; e.err = v.exp_err;
    exp_q.push_back(e);
    $display("txn %s we=%0d size=%0d sgn=%0d addr=%h wdata=%h", name, v.we, v.size, v.sgn, v.addr, v.wdata);
  endtask

  task automatic idle();
    @(negedge clk);
    bus.req = 1'b0;
  endtask

  // Called at a negedge with clr low; counts edges until busy drops, optionally poking a request on edge req_cyc.
  task automatic wait_sweep(input int req_cyc, output int n);
    n = 0;
    while (n < 3000) begin
      bus.req  = (n + 1 == req_cyc);
      bus.we   = 1'b0;
      bus.size = 2'b10;
      bus.addr = '0;
      @(posedge clk);
      #1;
      n++;
      if (n == req_cyc) chk("req_ignored_in_sweep", {31'b0, bus.ack}, 32'd0);
      if (!bus.busy) break;
      @(negedge clk);
    end
    @(negedge clk);
    bus.req = 1'b0;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        exp_t e;
        e = exp_q.pop_front();
        chk({e.name, "_ack"}, {31'b0, bus.ack}, 32'd1);
        chk({e.name, "_rdata"}, bus.rdata, e.rdata);
        chk({e.name, "_err"}, {31'b0, bus.err}, {31'b0, e.err});
      end else if (bus.ack) begin
        chk("unexpected_ack", {31'b0, bus.ack}, 32'd0);
      end else begin
        chk("idle_outputs_zero", {bus.rdata[31:1], bus.rdata[0] | bus.err}, 32'd0);
      end
    end
  end

  initial begin
    int   n;
    vec_t v;

    bus.req = 1'b0; bus.we = 1'b0; bus.size = 2'b10; bus.sgn = 1'b0;
    bus.addr = '0; bus.wdata = '0;

    repeat (2) @(posedge clk);
    #1;
    chk("reset_rdata", bus.rdata, 32'd0);
    chk("reset_ack", {31'b0, bus.ack}, 32'd0);
    chk("reset_err", {31'b0, bus.err}, 32'd0);
    chk("reset_busy", {31'b0, bus.busy}, 32'd1);

    @(negedge clk);
    clr = 1'b0;
    wait_sweep(0, n);
    chk("boot_sweep_len", n, DEPTH);

    for (int i = 0; i < 4; i++) begin
      v = '{1'b1, 2'b10, 1'b0, AW'(4 * i), 32'hFFFF_FFFF, 32'd0, 1'b0};
      issue($sformatf("fill%0d", i), v);
    end
    v = '{1'b0, 2'b10, 1'b0, 12'h00C, 32'd0, 32'hFFFF_FFFF, 1'b0};
    issue("fill_readback", v);
    idle();

    @(negedge clk);
    clr = 1'b1;
    @(posedge clk);
    #1;
    chk("busy_during_clr", {31'b0, bus.busy}, 32'd1);
    @(negedge clk);
    clr = 1'b0;
    wait_sweep(5, n);
    chk("clear_sweep_len", n, DEPTH);
    v = '{1'b0, 2'b10, 1'b0, 12'h00C, 32'd0, 32'h0000_0000, 1'b0};
    issue("cleared_00c", v);
    v = '{1'b0, 2'b10, 1'b0, 12'h000, 32'd0, 32'h0000_0000, 1'b0};
    issue("cleared_000", v);
    idle();

    add(1'b1, 2'b10, 1'b0, 12'h010, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0);
    add(1'b0, 2'b10, 1'b0, 12'h010, 32'd0,         32'hDEAD_BEEF, 1'b0);
    add(1'b1, 2'b10, 1'b0, 12'h000, 32'h1234_5678, 32'h0000_0000, 1'b0);
    add(1'b0, 2'b10, 1'b0, 12'h006, 32'd0,         32'h0000_0000, 1'b1);
    add(1'b1, 2'b01, 1'b0, 12'h003, 32'h0000_9999, 32'h0000_0000, 1'b1);
    add(1'b0, 2'b10, 1'b0, 12'h000, 32'd0,         32'h1234_5678, 1'b0);
`ifdef DMEM_SUBWORD_EN
    add(1'b1, 2'b10, 1'b0, 12'h020, 32'h1122_3344, 32'h0000_0000, 1'b0);
    add(1'b1, 2'b00, 1'b0, 12'h021, 32'h0000_00AA, 32'h0000_0000, 1'b0);
    add(1'b0, 2'b10, 1'b0, 12'h020, 32'd0,         32'h1122_AA44, 1'b0);
    add(1'b0, 2'b00, 1'b1, 12'h021, 32'd0,         32'hFFFF_FFAA, 1'b0);
    add(1'b0, 2'b01, 1'b0, 12'h022, 32'd0,         32'h0000_1122, 1'b0);
    add(1'b0, 2'b01, 1'b1, 12'h020, 32'd0,         32'hFFFF_AA44, 1'b0);
    add(1'b1, 2'b01, 1'b0, 12'h022, 32'h0000_BEEF, 32'h0000_0000, 1'b0);
    add(1'b0, 2'b10, 1'b0, 12'h020, 32'd0,         32'hBEEF_AA44, 1'b0);
    add(1'b0, 2'b00, 1'b0, 12'h023, 32'd0,         32'h0000_00BE, 1'b0);
    add(1'b0, 2'b11, 1'b0, 12'h020, 32'd0,         32'h0000_0000, 1'b1);
`else
    add(1'b0, 2'b00, 1'b0, 12'h021, 32'd0,         32'h0000_0000, 1'b1);
    add(1'b1, 2'b00, 1'b0, 12'h020, 32'h0000_00AA, 32'h0000_0000, 1'b0);
    add(1'b0, 2'b00, 1'b0, 12'h020, 32'd0,         32'h0000_00AA, 1'b0);
    add(1'b0, 2'b01, 1'b1, 12'h020, 32'd0,         32'h0000_00AA, 1'b0);
    add(1'b0, 2'b11, 1'b0, 12'h020, 32'd0,         32'h0000_00AA, 1'b0);
`endif
    foreach (vecs[i]) issue($sformatf("vec%0d", i), vecs[i]);
    idle();

    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    repeat (500) @(posedge clk);
    #1;
    chk("busy_mid_sweep", {31'b0, bus.busy}, 32'd1);
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    wait_sweep(0, n);
    chk("restart_sweep_len", n, DEPTH);
    v = '{1'b0, 2'b10, 1'b0, 12'h010, 32'd0, 32'h0000_0000, 1'b0};
    issue("restart_cleared_010", v);
    idle();

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
